rand_dealer: RTL and testbench
==============================

Name: rand_dealer

Overview:
- Consumer end of the 16-bit LFSR random-number generator.
- Pulls LFSR words one at a time by driving the generator's advance (button) input, then reduces each word to a bounded value by rejection sampling.
- Deals N_SLOTS distinct values (a random permutation of game cells for the 3x3 board) into the board-state logic, one write strobe per slot.
- Sits between the random-number generator and the board/display logic.

Parameters:
- N_SLOTS, 9, number of distinct values dealt per start; 1..16, must be <= RANGE.
- RANGE, 9, values are drawn from 0..RANGE-1; 1..16.
- MAX_TRIES, 64, consecutive rejects before deterministic fallback; 1..255.

Ports:
- f_crystal  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new deal; sampled only in IDLE.
- rnd_in  in  16  current LFSR word from the generator; only bits [3:0] are used.
- rnd_step  out  1  advance request to the generator, high for exactly one cycle per draw.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse after the last slot is written.
- slot_wr  out  1  one-cycle strobe; slot_idx and slot_val are valid while it is high.
- slot_idx  out  4  slot number, 0..N_SLOTS-1, ascending.
- slot_val  out  4  dealt value, 0..RANGE-1.
- used_mask  out  RANGE  bit v set once value v has been dealt in the current or last deal.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE.
  - busy, done, slot_wr, slot_idx, slot_val, used_mask, reject counter and candidate all go to 0.
  - A deal interrupted by reset is abandoned: no done pulse, and no further slot_wr until a new start.
- All outputs are registered, except rnd_step, which is decoded from the state register (state==DRAW) and is therefore glitch-free.
- FSM states: IDLE, DRAW, CHECK, EMIT, DONE.
- IDLE:
  - On start=1: clear used_mask, slot counter and reject counter; go to DRAW.
  - Otherwise stay in IDLE.
- DRAW (1 cycle):
  - rnd_step=1.
  - On the exit edge, cand <= rnd_in[3:0]; the generator shifts on the same edge.
  - Go to CHECK.
- CHECK (1 cycle):
  - Accept if cand < RANGE and used_mask[cand]==0: go to EMIT with slot_val <= cand; reject counter <= 0.
  - Otherwise, if reject counter == MAX_TRIES-1: fallback. Go to EMIT with slot_val <= lowest-index unused value; reject counter <= 0.
  - Otherwise increment the reject counter and go back to DRAW.
- EMIT (1 cycle):
  - slot_wr=1, slot_idx = current slot counter.
  - used_mask[slot_val] is set on the same edge that raises slot_wr.
  - On exit, the slot counter increments.
  - If this was slot N_SLOTS-1, go to DONE; otherwise go to DRAW.
- DONE (1 cycle): done=1, busy=1; then go to IDLE with busy=0.
- Latency with no rejects:
  - slot k is written in cycle 3k+3 after the start-sampling edge.
  - done is high in cycle 3*N_SLOTS+1 (28 for the defaults).
  - Each reject adds 2 cycles.
- start is ignored in DRAW, CHECK, EMIT and DONE; it is not queued. A start in the cycle after DONE is accepted.
- used_mask keeps its final value after done and is cleared only by the next accepted start or by reset.
- The fallback guarantees termination when the LFSR is stuck or RANGE is sparse. Worst case per slot is MAX_TRIES*2+1 cycles.

Decomposition:
- Shared package rand_pkg holds:
  - state encoding (IDLE/DRAW/CHECK/EMIT/DONE, 3 bits);
  - VAL_W=4 and IDX_W=4;
  - LFSR_W=16, shared with the generator.
- One sub-module, first_free_enc: a combinational priority encoder from used_mask to the lowest zero-bit index, used for the fallback.

Test Plan:
1. Reset: hold rst=0 mid-run -> busy=0, done=0, slot_wr=0, used_mask=0, rnd_step=0 immediately, without waiting for a clock edge.
2. No rejects: bench model supplies low nibbles 3,5,1,0,8,2,7,4,6 on successive rnd_step -> slots 0..8 get 3,5,1,0,8,2,7,4,6; exactly 9 rnd_step pulses; done in cycle 28; used_mask=9'h1FF.
3. Rejection: nibbles 12,3,3,15,5 -> 12 rejected (>=RANGE), the second 3 rejected (already used), 15 rejected; slot0=3, slot1=5; 5 rnd_step pulses; slot1 written in cycle 12.
4. Stuck LFSR: rnd_in held at 16'h0000 -> slot0=0, each later slot i=i via fallback after 64 rejects; done asserted; used_mask=9'h1FF.
5. Reset mid-deal after 4 slots: rst pulse low -> no done pulse and no further slot_wr; the next start produces a fresh 9-slot deal from used_mask=0.
6. start held high during busy and during DONE -> no restart and slot_idx stays ascending; start in the cycle after done -> new deal begins, used_mask cleared.

Source files
------------

// File: rtl/rand_dealer_pkg.sv
// Shared types and widths for the random dealer and its LFSR generator.
package rand_pkg;

  localparam int LFSR_W = 16;
  localparam int VAL_W  = 4;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rand_dealer_if.sv
// Dealer bus: start/LFSR inputs plus the slot-write stream toward the board logic.
interface rand_dealer_if
  import rand_pkg::*;
#(
  parameter int RANGE = 9
) ();

  logic              start;
  logic [LFSR_W-1:0] rnd_in;
  logic              rnd_step;
  logic              busy;
  logic              done;
  logic              slot_wr;
  logic [IDX_W-1:0]  slot_idx;
  logic [VAL_W-1:0]  slot_val;
  logic [RANGE-1:0]  used_mask;

  modport master (
    output start, rnd_in,
    input  rnd_step, busy, done, slot_wr, slot_idx, slot_val, used_mask
  );

  modport slave (
    input  start, rnd_in,
    output rnd_step, busy, done, slot_wr, slot_idx, slot_val, used_mask
  );

endinterface

// File: rtl/rand_dealer_first_free_enc.sv
// Priority encoder: index of the lowest clear bit in a mask (0 if the mask is full).
module first_free_enc
  import rand_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0]     i_mask,
  output logic [VAL_W-1:0] o_idx
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!i_mask[i]) o_idx = VAL_W'(i);
    end
  end

endmodule

// File: rtl/rand_dealer.sv
// Deals N_SLOTS distinct values in 0..RANGE-1 drawn from the LFSR by rejection sampling,
// falling back to the lowest unused value after MAX_TRIES consecutive rejects.
module rand_dealer
  import rand_pkg::*;
#(
  parameter int N_SLOTS   = 9,
  parameter int RANGE     = 9,
  parameter int MAX_TRIES = 64
) (
  input logic          i_f_crystal,
  input logic          i_rst,
  rand_dealer_if.slave io_bus
);

  localparam int                VALS      = 1 << VAL_W;
  localparam logic [VAL_W:0]    RANGE_LIM = (VAL_W + 1)'(RANGE);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(N_SLOTS - 1);
  localparam logic [7:0]        LAST_TRY  = 8'(MAX_TRIES - 1);

  state_t           r_state, w_state_nx;
  logic [VAL_W-1:0] r_cand, w_cand_nx;
  logic [7:0]       r_rej, w_rej_nx;
  logic [IDX_W-1:0] r_slot, w_slot_nx;
  logic [RANGE-1:0] r_used, w_used_nx;
  logic [VAL_W-1:0] r_val, w_val_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic             r_wr, w_wr_nx;
  logic             r_done, w_done_nx;
  logic             r_busy, w_busy_nx;

  logic [VAL_W-1:0] w_first_free;
  logic [VALS-1:0]  w_used_ext;
  logic [VALS-1:0]  w_onehot;
  logic             w_accept;
  logic [VAL_W-1:0] w_pick;
  logic             w_unused_rnd;

  first_free_enc #(.W(RANGE)) u_first_free (
    .i_mask (r_used),
    .o_idx  (w_first_free)
  );

  // Widen the mask so any 4-bit candidate indexes it safely, even values >= RANGE.
  assign w_used_ext   = VALS'(r_used);
  assign w_accept     = ({1'b0, r_cand} < RANGE_LIM) && !w_used_ext[r_cand];
  assign w_pick       = w_accept ? r_cand : w_first_free;
  assign w_onehot     = VALS'(1) << w_pick;
  assign w_unused_rnd = ^io_bus.rnd_in[LFSR_W-1:VAL_W];

  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_rej_nx   = r_rej;
    w_slot_nx  = r_slot;
    w_used_nx  = r_used;
    w_val_nx   = r_val;
    w_idx_nx   = r_idx;
    w_wr_nx    = 1'b0;
    w_done_nx  = 1'b0;
    w_busy_nx  = r_busy;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_used_nx  = '0;
          w_slot_nx  = '0;
          w_rej_nx   = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = DRAW;
        end
      end
      DRAW: begin
        w_cand_nx  = io_bus.rnd_in[VAL_W-1:0];
        w_state_nx = CHECK;
      end
      CHECK: begin
        if (w_accept || r_rej == LAST_TRY) begin
          w_val_nx   = w_pick;
          w_used_nx  = r_used | RANGE'(w_onehot);
          w_idx_nx   = r_slot;
          w_wr_nx    = 1'b1;
          w_rej_nx   = '0;
          w_state_nx = EMIT;
        end else begin
          w_rej_nx   = r_rej + 8'd1;
          w_state_nx = DRAW;
        end
      end
      EMIT: begin
        w_slot_nx = r_slot + IDX_W'(1);
        if (r_slot == LAST_SLOT) begin
          w_done_nx  = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_state_nx = DRAW;
        end
      end
      DONE: begin
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_f_crystal or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_rej   <= '0;
      r_slot  <= '0;
      r_used  <= '0;
      r_val   <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_rej   <= w_rej_nx;
      r_slot  <= w_slot_nx;
      r_used  <= w_used_nx;
      r_val   <= w_val_nx;
      r_idx   <= w_idx_nx;
      r_wr    <= w_wr_nx;
      r_done  <= w_done_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign io_bus.rnd_step  = (r_state == DRAW);
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.slot_wr   = r_wr;
  assign io_bus.slot_idx  = r_idx;
  assign io_bus.slot_val  = r_val;
  assign io_bus.used_mask = r_used;

endmodule

// File: tb/tb_rand_dealer.sv
// Scoreboard bench for rand_dealer: a word-stream generator feeds the DUT and a
// deal-level reference model predicts every slot write and done pulse.
module tb_rand_dealer;

  localparam int N_SLOTS   = 9;
  localparam int RANGE     = 9;
  localparam int MAX_TRIES = 64;

  typedef struct { int idx; int val; int cyc; } slot_exp_t;
  typedef struct { int cyc; int mask; int steps; } done_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rand_dealer_if #(.RANGE(RANGE)) bus ();

  rand_dealer #(
    .N_SLOTS   (N_SLOTS),
    .RANGE     (RANGE),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .i_f_crystal (clk),
    .i_rst       (rst_n),
    .io_bus      (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int genPos = 0;
  int modelPos = 0;
  bit stepPending = 1'b0;
  int slotsSeen = 0;
  int lastDoneCyc = -1;
  int slotCyc[16];
  int slotSteps[16];
  logic [15:0] stream[$];
  logic [3:0]  prefix[$];
  slot_exp_t expQ[$];
  done_exp_t doneQ[$];
  slot_exp_t monE;
  done_exp_t monD;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    nChecks++;
    if (actual !== 32'(expected)) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [15:0] word(input int i);
    return (i < stream.size()) ? stream[i] : 16'h0000;
  endfunction

  // Prefix nibbles get random upper bits; the rest is random or stuck at zero.
  task automatic loadStream(input bit stuck);
    stream.delete();
    foreach (prefix[i]) stream.push_back({12'($urandom()), prefix[i]});
    if (!stuck) repeat (1200) stream.push_back(16'($urandom()));
    genPos     = 0;
    modelPos   = 0;
    bus.rnd_in = word(0);
  endtask

  // Deal-level model: draw words, accept fresh in-range values, fall back to the
  // lowest free value on the MAX_TRIES-th failed attempt. Each attempt is 2 cycles,
  // each write 1 cycle; cycle 1 is the interval right after the start edge.
  task automatic modelDeal(input int c0, output int t);
    bit used[16];
    int mask;
    slot_exp_t e;
    done_exp_t d;
    used = '{default: 1'b0};
    t    = 0;
    mask = 0;
    for (int k = 0; k < N_SLOTS; k++) begin
      int tries;
      int pick;
      int c;
      tries = 0;
      pick  = -1;
      while (pick < 0) begin
        c = int'(word(modelPos) & 16'h000F);
        modelPos++;
        tries++;
        t += 2;
        if (c < RANGE && !used[c]) pick = c;
        else if (tries == MAX_TRIES)
          for (int v = RANGE - 1; v >= 0; v--) if (!used[v]) pick = v;
      end
      used[pick] = 1'b1;
      mask |= (1 << pick);
      t += 1;
      e.idx = k; e.val = pick; e.cyc = c0 + t - 1;
      expQ.push_back(e);
    end
    d.cyc = c0 + t; d.mask = mask; d.steps = modelPos;
    doneQ.push_back(d);
  endtask

  always @(posedge clk) cyc++;

  // Generator: shifts on the edge that ends a DRAW cycle.
  always @(negedge clk) stepPending = bus.rnd_step;
  always @(posedge clk) begin
    if (stepPending) begin
      stepPending = 1'b0;
      genPos++;
      #1 bus.rnd_in = word(genPos);
    end
  end

  always @(negedge clk) begin
    if (bus.slot_wr !== 1'b0) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpected slot_wr: idx=%0d val=%0d, expected no write", bus.slot_idx, bus.slot_val);
      end else begin
        monE = expQ.pop_front();
        checkOutput("slot_idx", 32'(bus.slot_idx), monE.idx);
        checkOutput($sformatf("slot%0d val", monE.idx), 32'(bus.slot_val), monE.val);
        checkOutput($sformatf("slot%0d cycle", monE.idx), 32'(cyc), monE.cyc);
        slotCyc[monE.idx]   = cyc;
        slotSteps[monE.idx] = genPos;
        slotsSeen++;
      end
    end
    if (bus.done !== 1'b0) begin
      if (doneQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpected done: got 1, expected 0");
      end else begin
        monD = doneQ.pop_front();
        checkOutput("done cycle", 32'(cyc), monD.cyc);
        checkOutput("used_mask at done", 32'(bus.used_mask), monD.mask);
        checkOutput("rnd_step count at done", 32'(genPos), monD.steps);
        checkOutput("busy during done", 32'(bus.busy), 1);
        lastDoneCyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input bit hold, output int c0, output int t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    slotsSeen = 0;
    bus.start = 1'b1;
    c0 = cyc + 1;
    modelDeal(c0, t);
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic waitDrained(input string name, input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || doneQ.size() != 0) && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, " drained"}, 32'(expQ.size() == 0 && doneQ.size() == 0), 1);
    expQ.delete();
    doneQ.delete();
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " busy"}, 32'(bus.busy), 0);
    checkOutput({name, " done"}, 32'(bus.done), 0);
    checkOutput({name, " slot_wr"}, 32'(bus.slot_wr), 0);
    checkOutput({name, " used_mask"}, 32'(bus.used_mask), 0);
    checkOutput({name, " rnd_step"}, 32'(bus.rnd_step), 0);
  endtask

  initial begin
    int c0;
    int c1;
    int t;
    int t2;
    int n;
    bus.start  = 1'b0;
    bus.rnd_in = 16'h0000;

    #3 rst_n = 1'b0;
    #1;
    checkResetState("reset");
    checkOutput("reset slot_idx", 32'(bus.slot_idx), 0);
    checkOutput("reset slot_val", 32'(bus.slot_val), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] no-reject deal");
    prefix = '{4'd3, 4'd5, 4'd1, 4'd0, 4'd8, 4'd2, 4'd7, 4'd4, 4'd6};
    loadStream(1'b0);
    applyStimulus(1'b0, c0, t);
    waitDrained("t2", 200);
    checkOutput("t2 done cycle", 32'(lastDoneCyc - c0 + 1), 28);
    checkOutput("t2 rnd_step pulses", 32'(genPos), 9);
    checkOutput("t2 used_mask", 32'(bus.used_mask), 'h1FF);

    $display("[TB] rejection deal");
    prefix = '{4'd12, 4'd3, 4'd3, 4'd15, 4'd5};
    loadStream(1'b0);
    applyStimulus(1'b0, c0, t);
    waitDrained("t3", 2000);
    checkOutput("t3 slot0 cycle", 32'(slotCyc[0] - c0 + 1), 5);
    checkOutput("t3 slot1 cycle", 32'(slotCyc[1] - c0 + 1), 12);
    checkOutput("t3 steps at slot1", 32'(slotSteps[1]), 5);

    $display("[TB] stuck generator");
    prefix.delete();
    loadStream(1'b1);
    applyStimulus(1'b0, c0, t);
    waitDrained("t4", 3000);
    checkOutput("t4 done cycle", 32'(lastDoneCyc - c0 + 1), 1036);
    checkOutput("t4 rnd_step pulses", 32'(genPos), 513);
    checkOutput("t4 used_mask", 32'(bus.used_mask), 'h1FF);

    $display("[TB] reset mid-deal");
    loadStream(1'b0);
    applyStimulus(1'b0, c0, t);
    n = 0;
    while (slotsSeen < 4 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("t5 slots before reset", 32'(slotsSeen), 4);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("t5 async reset");
    expQ.delete();
    doneQ.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t5 busy after reset", 32'(bus.busy), 0);
    checkOutput("t5 writes after reset", 32'(slotsSeen), 4);
    loadStream(1'b0);
    applyStimulus(1'b0, c0, t);
    waitDrained("t5 redeal", 2000);
    checkOutput("t5 redeal used_mask", 32'(bus.used_mask), 'h1FF);

    $display("[TB] start held through busy and done");
    loadStream(1'b0);
    applyStimulus(1'b1, c0, t);
    c1 = c0 + t + 2;
    modelDeal(c1, t2);
    n = 0;
    while (cyc < c1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("t6 restart cycle reached", 32'(cyc), c1);
    checkOutput("t6 used_mask cleared", 32'(bus.used_mask), 0);
    checkOutput("t6 busy on restart", 32'(bus.busy), 1);
    bus.start = 1'b0;
    waitDrained("t6", 3000);

    $display("[TB] random deals");
    for (int r = 0; r < 3; r++) begin
      prefix.delete();
      loadStream(1'b0);
      applyStimulus(1'b0, c0, t);
      waitDrained($sformatf("random%0d", r), 3000);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #400000;
    nErrors++;
    nChecks++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
